// File: rtl/sdram_pattern_tester.sv
// Self-test engine for the SDRAM controller command/read ports: fills a range
// with a pattern, reads it back, counts mismatches and captures the first one.
module sdram_pattern_tester #(
  parameter int                 ADDR_W     = 23,
  parameter int                 DATA_W     = 32,
  parameter logic [ADDR_W-1:0]  START_ADDR = '0,
  parameter logic [ADDR_W-1:0]  END_ADDR   = '1,
  parameter logic [DATA_W-1:0]  LFSR_TAPS  = DATA_W'(32'h80200003),
  parameter int                 ERR_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            mode,
  input  logic                  phased,
  input  logic                  stop_on_err,
  input  logic [DATA_W-1:0]     seed,
  input  logic                  mem_cmd_ready,
  output logic                  mem_cmd_enable,
  output logic                  mem_cmd_wr,
  output logic [ADDR_W-1:0]     mem_cmd_address,
  output logic [DATA_W-1:0]     mem_cmd_data_in,
  output logic [DATA_W/8-1:0]   mem_cmd_byte_enable,
  input  logic [DATA_W-1:0]     mem_data_out,
  input  logic                  mem_data_out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  aborted,
  output logic [ERR_W-1:0]      err_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic [DATA_W-1:0]     first_err_exp,
  output logic [DATA_W-1:0]     first_err_act
);
  localparam logic [1:0] M_INCR = 2'd0, M_ADDR = 2'd1, M_WALK = 2'd2, M_LFSR = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_WR_REQ, S_RD_REQ, S_RD_WAIT, S_CMP, S_DONE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   pat, seed_r, rd_data, expect_data;
  logic [1:0]          mode_r;
  logic                phased_r, stop_r, abort_pend, cmd_en, cmd_wr;
  logic                accept, mismatch, end_now;

  function automatic logic [DATA_W-1:0] pat_init(input logic [1:0] m, input logic [DATA_W-1:0] s);
    case (m)
      M_WALK:  pat_init = DATA_W'(1);
      M_LFSR:  pat_init = (s == '0) ? DATA_W'(1) : s;
      default: pat_init = s;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] pat_next(input logic [1:0] m, input logic [DATA_W-1:0] p);
    case (m)
      M_INCR:  pat_next = p + DATA_W'(1);
      M_WALK:  pat_next = {p[DATA_W-2:0], p[DATA_W-1]};
      M_LFSR:  pat_next = (p >> 1) ^ (p[0] ? LFSR_TAPS : '0);
      default: pat_next = p;
    endcase
  endfunction

  // Address mode derives data from the address; the other modes walk pat.
  assign expect_data         = (mode_r == M_ADDR) ? DATA_W'(addr) : pat;
  assign mismatch            = (rd_data != expect_data);
  assign accept              = cmd_en && mem_cmd_ready;
  assign end_now             = (stop_r && mismatch) || (addr == END_ADDR) || abort_pend || abort;
  assign mem_cmd_enable      = cmd_en;
  assign mem_cmd_wr          = cmd_wr;
  assign mem_cmd_address     = addr;
  assign mem_cmd_data_in     = expect_data;
  assign mem_cmd_byte_enable = {(DATA_W/8){busy}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE; addr <= '0; pat <= '0; seed_r <= '0; rd_data <= '0;
      mode_r <= '0; phased_r <= 1'b0; stop_r <= 1'b0; abort_pend <= 1'b0;
      cmd_en <= 1'b0; cmd_wr <= 1'b0; busy <= 1'b0; done <= 1'b0; pass <= 1'b0;
      aborted <= 1'b0; err_count <= '0; first_err_addr <= '0;
      first_err_exp <= '0; first_err_act <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start && !abort) begin
          mode_r <= mode; phased_r <= phased; stop_r <= stop_on_err; seed_r <= seed;
          pat <= pat_init(mode, seed); addr <= START_ADDR; abort_pend <= 1'b0;
          err_count <= '0; first_err_addr <= '0; first_err_exp <= '0; first_err_act <= '0;
          done <= 1'b0; pass <= 1'b0; aborted <= 1'b0; busy <= 1'b1;
          cmd_en <= 1'b1; cmd_wr <= 1'b1; state <= S_WR_REQ;
        end
        S_WR_REQ: begin
          if (accept && !abort) begin
            if (!phased_r) begin
              cmd_wr <= 1'b0; state <= S_RD_REQ;
            end else if (addr == END_ADDR) begin
              // Fill finished: rewind address and pattern for the verify pass.
              addr <= START_ADDR; pat <= pat_init(mode_r, seed_r);
              cmd_wr <= 1'b0; state <= S_RD_REQ;
            end else begin
              addr <= addr + ADDR_W'(1); pat <= pat_next(mode_r, pat);
            end
          end else if (abort) begin
            cmd_en <= 1'b0; busy <= 1'b0; done <= 1'b0 | 1'b1; aborted <= 1'b1;
            pass <= 1'b0; state <= S_DONE;
          end
        end
        S_RD_REQ: begin
          if (accept) begin
            cmd_en <= 1'b0; abort_pend <= abort; state <= S_RD_WAIT;
          end else if (abort) begin
            cmd_en <= 1'b0; busy <= 1'b0; done <= 1'b1; aborted <= 1'b1;
            pass <= 1'b0; state <= S_DONE;
          end
        end
        S_RD_WAIT: begin
          if (abort) abort_pend <= 1'b1;
          if (mem_data_out_ready) begin
            rd_data <= mem_data_out; state <= S_CMP;
          end
        end
        S_CMP: begin
          if (mismatch) begin
            if (!(&err_count)) err_count <= err_count + ERR_W'(1);
            if (err_count == '0) begin
              first_err_addr <= addr; first_err_exp <= expect_data; first_err_act <= rd_data;
            end
          end
          if (end_now) begin
            busy <= 1'b0; done <= 1'b1; aborted <= abort_pend || abort;
            pass <= !(abort_pend || abort) && (err_count == '0) && !mismatch;
            state <= S_DONE;
          end else begin
            addr <= addr + ADDR_W'(1); pat <= pat_next(mode_r, pat);
            cmd_en <= 1'b1; cmd_wr <= !phased_r;
            state <= phased_r ? S_RD_REQ : S_WR_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Scoreboard bench: stimulus pushes expected commands and final status, a
// negedge monitor pops and compares on every accepted command and on done.
module tb_sdram_pattern_tester;
  localparam int AW = 3, DW = 32, EW = 16;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, phased = 1'b0, stop_on_err = 1'b0;
  logic [1:0] mode = '0;
  logic [DW-1:0] seed = '0;
  logic mem_cmd_ready, mem_cmd_enable, mem_cmd_wr, mem_data_out_ready;
  logic [AW-1:0] mem_cmd_address, first_err_addr;
  logic [DW-1:0] mem_cmd_data_in, mem_data_out, first_err_exp, first_err_act;
  logic [DW/8-1:0] mem_cmd_byte_enable;
  logic busy, done, pass, aborted;
  logic [EW-1:0] err_count;

  always #5 clk = ~clk;

  sdram_pattern_tester #(.ADDR_W(AW), .DATA_W(DW), .START_ADDR(3'd2), .ERR_W(EW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .phased(phased),
    .stop_on_err(stop_on_err), .seed(seed), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_enable(mem_cmd_enable), .mem_cmd_wr(mem_cmd_wr), .mem_cmd_address(mem_cmd_address),
    .mem_cmd_data_in(mem_cmd_data_in), .mem_cmd_byte_enable(mem_cmd_byte_enable),
    .mem_data_out(mem_data_out), .mem_data_out_ready(mem_data_out_ready), .busy(busy),
    .done(done), .pass(pass), .aborted(aborted), .err_count(err_count),
    .first_err_addr(first_err_addr), .first_err_exp(first_err_exp), .first_err_act(first_err_act));

  typedef struct packed {logic wr; logic [AW-1:0] addr; logic [DW-1:0] data;} cmd_t;
  typedef struct {logic pass, ab; logic [EW-1:0] err; logic [AW-1:0] fa; logic [DW-1:0] fe, fx;} st_t;
  cmd_t cmd_q[$];
  st_t  st_q[$];
  int checks = 0, passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_w(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_q.push_back({1'b1, a, d});
  endtask
  task automatic push_r(input logic [AW-1:0] a);
    cmd_q.push_back({1'b0, a, {DW{1'b0}}});
  endtask
  task automatic push_st(input logic p, ab, input logic [EW-1:0] e, input logic [AW-1:0] fa,
                         input logic [DW-1:0] fe, fx);
    st_t s;
    s.pass = p; s.ab = ab; s.err = e; s.fa = fa; s.fe = fe; s.fx = fx;
    st_q.push_back(s);
  endtask

  // Memory model: stall-able ready, 3-cycle read latency, per-address bit0 corruption.
  int stall_n = 0, wait_cnt, rd_cnt;
  logic hang = 1'b0;
  logic [7:0] corrupt = '0;
  logic [DW-1:0] mem [8];
  logic [AW-1:0] rd_addr;
  assign mem_cmd_ready = (wait_cnt >= stall_n);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= 0; rd_cnt <= 0; mem_data_out_ready <= 1'b0; mem_data_out <= '0; rd_addr <= '0;
    end else begin
      mem_data_out_ready <= 1'b0;
      wait_cnt <= (!mem_cmd_enable || mem_cmd_ready) ? 0 : wait_cnt + 1;
      if (mem_cmd_enable && mem_cmd_ready && mem_cmd_wr) mem[mem_cmd_address] <= mem_cmd_data_in;
      if (mem_cmd_enable && mem_cmd_ready && !mem_cmd_wr) begin
        rd_cnt <= 3; rd_addr <= mem_cmd_address;
      end else if (rd_cnt == 1) begin
        if (!hang) begin
          mem_data_out_ready <= 1'b1;
          mem_data_out <= mem[rd_addr] ^ {{(DW-1){1'b0}}, corrupt[rd_addr]};
          rd_cnt <= 0;
        end
      end else if (rd_cnt != 0) rd_cnt <= rd_cnt - 1;
    end
  end

  // Monitor
  logic done_q = 1'b0, held_v = 1'b0;
  cmd_t held, mc;
  st_t  ms;
  always @(negedge clk) begin
    if (!rst) begin
      done_q <= 1'b0; held_v <= 1'b0;
    end else begin
      if (mem_cmd_enable && mem_cmd_ready) begin
        chk("cmd_expected", cmd_q.size() != 0, 1);
        if (cmd_q.size() != 0) begin
          mc = cmd_q.pop_front();
          chk("cmd_wr", mem_cmd_wr, mc.wr);
          chk("cmd_addr", mem_cmd_address, mc.addr);
          if (mc.wr) chk("cmd_wdata", mem_cmd_data_in, mc.data);
          chk("byte_en", mem_cmd_byte_enable, 4'hF);
        end
        held_v <= 1'b0;
      end else if (mem_cmd_enable) begin
        if (held_v) chk("cmd_hold_stable", {mem_cmd_wr, mem_cmd_address, mem_cmd_data_in}, held);
        held <= {mem_cmd_wr, mem_cmd_address, mem_cmd_data_in};
        held_v <= 1'b1;
      end else held_v <= 1'b0;
      if (done && !done_q) begin
        chk("cmd_q_drained", cmd_q.size(), 0);
        chk("status_expected", st_q.size() != 0, 1);
        if (st_q.size() != 0) begin
          ms = st_q.pop_front();
          chk("pass", pass, ms.pass);
          chk("aborted", aborted, ms.ab);
          chk("err_count", err_count, ms.err);
          chk("first_err_addr", first_err_addr, ms.fa);
          chk("first_err_exp", first_err_exp, ms.fe);
          chk("first_err_act", first_err_act, ms.fx);
          chk("busy_at_done", busy, 0);
        end
      end
      done_q <= done;
    end
  end

  // Inputs are changed right after the start pulse to check they were sampled.
  task automatic run(input logic [1:0] m, input logic ph, st, input logic [DW-1:0] sd);
    @(negedge clk);
    mode = m; phased = ph; stop_on_err = st; seed = sd; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mode = ~m; phased = ~ph; stop_on_err = ~st; seed = ~sd;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 3000) begin @(negedge clk); n++; end
    chk("done_within_budget", done, 1);
    @(negedge clk);
  endtask

  task automatic wait_rd_accept(input logic [AW-1:0] a);
    int n = 0;
    while (!(mem_cmd_enable && mem_cmd_ready && !mem_cmd_wr && mem_cmd_address == a) && n < 2000) begin
      @(negedge clk); n++;
    end
    chk("rd_accept_seen", n < 2000, 1);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_enable"}, mem_cmd_enable, 0);
    chk({tag, "_wr"}, mem_cmd_wr, 0);
    chk({tag, "_addr"}, mem_cmd_address, 0);
    chk({tag, "_wdata"}, mem_cmd_data_in, 0);
    chk({tag, "_byte_en"}, mem_cmd_byte_enable, 0);
    chk({tag, "_status"}, {busy, done, pass, aborted}, 0);
    chk({tag, "_err"}, {err_count, first_err_addr}, 0);
    chk({tag, "_first_data"}, {first_err_exp, first_err_act}, 0);
  endtask

  logic [DW-1:0] lfsr_v [6] = '{32'h00000001, 32'h80200003, 32'hC0300002,
                                32'h60180001, 32'hB02C0003, 32'hD8360002};
  logic [DW-1:0] incr_v [6] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000,
                                32'h00000001, 32'h00000002, 32'h00000003};

  initial begin
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;

    // incr, per-address, seed 0x10 over 2..7
    for (int a = 2; a <= 7; a++) begin push_w(a, 32'h10 + a - 2); push_r(a); end
    push_st(1, 0, 0, 0, 0, 0);
    run(2'd0, 0, 0, 32'h10);
    wait_done();

    // LFSR, phased, seed 0 behaves as seed 1
    for (int a = 2; a <= 7; a++) push_w(a, lfsr_v[a-2]);
    for (int a = 2; a <= 7; a++) push_r(a);
    push_st(1, 0, 0, 0, 0, 0);
    run(2'd3, 1, 0, 32'h0);
    wait_done();

    // addr mode, bit0 corrupted at 4, continue past error
    corrupt = 8'h10;
    for (int a = 2; a <= 7; a++) begin push_w(a, a); push_r(a); end
    push_st(0, 0, 1, 4, 32'h4, 32'h5);
    run(2'd1, 0, 0, 32'h55);
    wait_done();

    // corrupt 3 and 4, stop at first error: nothing issued for addr 4
    corrupt = 8'h18;
    push_w(2, 2); push_r(2); push_w(3, 3); push_r(3);
    push_st(0, 0, 1, 3, 32'h3, 32'h2);
    run(2'd1, 0, 1, 32'h0);
    wait_done();

    // walking-one with a 5-cycle stall per command, abort during read wait
    corrupt = '0; stall_n = 5;
    push_w(2, 32'h1); push_r(2); push_w(3, 32'h2); push_r(3);
    push_st(0, 1, 0, 0, 0, 0);
    run(2'd2, 0, 0, 32'h0);
    wait_rd_accept(3);
    abort = 1'b1;
    wait_done();
    abort = 1'b0;

    // abort while a write is still unaccepted: no command completes
    push_st(0, 1, 0, 0, 0, 0);
    run(2'd0, 0, 0, 32'h0);
    @(negedge clk);
    abort = 1'b1;
    wait_done();
    abort = 1'b0;

    // start together with abort while idle is ignored
    @(negedge clk); abort = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("ignored_start_busy", busy, 0);
    chk("ignored_start_done", done, 1);
    chk("ignored_start_aborted", aborted, 1);
    chk("ignored_start_enable", mem_cmd_enable, 0);

    // reset in the middle of a read wait
    stall_n = 0; hang = 1'b1;
    push_w(2, 32'h20); push_r(2);
    run(2'd0, 0, 0, 32'h20);
    wait_rd_accept(2);
    rst = 1'b0;
    #1;
    chk_all_zero("async_reset");
    cmd_q.delete(); st_q.delete();
    @(negedge clk);
    rst = 1'b1; hang = 1'b0;

    // full test up to the top address, with data wrapping through zero
    for (int a = 2; a <= 7; a++) begin push_w(a, incr_v[a-2]); push_r(a); end
    push_st(1, 0, 0, 0, 0, 0);
    run(2'd0, 0, 0, 32'hFFFFFFFE);
    wait_done();
    repeat (8) @(negedge clk);
    chk("idle_after_top", {busy, mem_cmd_enable}, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
